// File: rtl/mov_sprite_scheduler.sv
// mov_sprite_scheduler: per-pixel scheduler between the VGA pixel pipeline and
// the moving-sprite memory (16x16 patterns, 2-bit pixels, 64 selectable patterns).
// Holds a NUM_SPR-entry instance table (x, y, select, enable). Each accepted pixel
// request scans the table in index order. Each overlapping instance gets one
// sprite-memory read, and the first non-transparent pixel found is returned.
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   cfg_we/idx/x/y/sel/en  sprite-table write port
//   pix_valid/ready/x/y    pixel request handshake (ready only while idle)
//   mem_x/y/select         registered sprite-memory read address
//   mem_data               memory pixel, valid MEM_LAT clocks after mem_* change
//   out_valid/pixel/hit/idx  one-clock result pulse; values held until next result
module mov_sprite_scheduler #(
    parameter int NUM_SPR = 8,
    parameter int COORD_W = 10,
    parameter int MEM_LAT = 1,
    localparam int IDX_W = $clog2(NUM_SPR)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [5:0]         cfg_sel,
    input  logic               cfg_en,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [3:0]         mem_x,
    output logic [3:0]         mem_y,
    output logic [5:0]         mem_select,
    input  logic [1:0]         mem_data,
    output logic               out_valid,
    output logic [1:0]         out_pixel,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_idx
);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [3:0]         mem_x_q, mem_x_d, mem_y_q, mem_y_d;
    logic [5:0]         mem_sel_q, mem_sel_d;
    logic [1:0]         out_pixel_q, out_pixel_d;
    logic               out_hit_q, out_hit_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

    logic               en_q  [NUM_SPR];
    logic               en_d  [NUM_SPR];
    logic [COORD_W-1:0] x_q   [NUM_SPR];
    logic [COORD_W-1:0] x_d   [NUM_SPR];
    logic [COORD_W-1:0] y_q   [NUM_SPR];
    logic [COORD_W-1:0] y_d   [NUM_SPR];
    logic [5:0]         sel_q [NUM_SPR];
    logic [5:0]         sel_d [NUM_SPR];

    logic [COORD_W-1:0] dx, dy;
    logic               hit, last;

    // Offsets are only meaningful once px>=sx / py>=sy; the upper-bits check
    // keeps instances at the screen edge clipped instead of wrapping.
    assign dx   = px_q - x_q[idx_q];
    assign dy   = py_q - y_q[idx_q];
    assign hit  = en_q[idx_q]
                  && (px_q >= x_q[idx_q]) && (dx[COORD_W-1:4] == '0)
                  && (py_q >= y_q[idx_q]) && (dy[COORD_W-1:4] == '0);
    assign last = (idx_q == IDX_W'(NUM_SPR - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        px_d        = px_q;
        py_d        = py_q;
        cnt_d       = cnt_q;
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;
        mem_sel_d   = mem_sel_q;
        out_pixel_d = out_pixel_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        en_d        = en_q;
        x_d         = x_q;
        y_d         = y_q;
        sel_d       = sel_q;

        if (cfg_we) begin
            en_d[cfg_idx]  = cfg_en;
            x_d[cfg_idx]   = cfg_x;
            y_d[cfg_idx]   = cfg_y;
            sel_d[cfg_idx] = cfg_sel;
        end

        unique case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    px_d    = pix_x;
                    py_d    = pix_y;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    mem_x_d   = dx[3:0];
                    mem_y_d   = dy[3:0];
                    mem_sel_d = sel_q[idx_q];
                    cnt_d     = 2'(MEM_LAT);
                    state_d   = WAIT;
                end else if (last) begin
                    out_pixel_d = '0;
                    out_hit_d   = 1'b0;
                    out_idx_d   = '0;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT: begin
                // mem_data is sampled on the edge that ends the last wait clock.
                if (cnt_q != 2'd1) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (mem_data != 2'd0) begin
                    out_pixel_d = mem_data;
                    out_hit_d   = 1'b1;
                    out_idx_d   = idx_q;
                    state_d     = DONE;
                end else if (last) begin
                    out_pixel_d = '0;
                    out_hit_d   = 1'b0;
                    out_idx_d   = '0;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            cnt_q       <= '0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            mem_sel_q   <= '0;
            out_pixel_q <= '0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            for (int i = 0; i < NUM_SPR; i++) en_q[i] <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cnt_q       <= cnt_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
            mem_sel_q   <= mem_sel_d;
            out_pixel_q <= out_pixel_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
            en_q        <= en_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_q       <= sel_d;
        end
    end

    assign pix_ready  = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mem_x      = mem_x_q;
    assign mem_y      = mem_y_q;
    assign mem_select = mem_sel_q;
    assign out_pixel  = out_pixel_q;
    assign out_hit    = out_hit_q;
    assign out_idx    = out_idx_q;

endmodule

// File: tb/tb_mov_sprite_scheduler.sv
// tb_mov_sprite_scheduler: random and directed requests checked against a
// table-scan reference model, with a pattern-array sprite memory model.
module tb_mov_sprite_scheduler;

    localparam int NSPR = 8;
    localparam int CW   = 10;
    localparam int LAT  = 1;
    localparam int IW   = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [CW-1:0] cfg_x, cfg_y;
    logic [5:0]    cfg_sel;
    logic          cfg_en;
    logic          pix_valid, pix_ready;
    logic [CW-1:0] pix_x, pix_y;
    logic [3:0]    mem_x, mem_y;
    logic [5:0]    mem_select;
    logic [1:0]    mem_data;
    logic          out_valid, out_hit;
    logic [1:0]    out_pixel;
    logic [IW-1:0] out_idx;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] pat [64][16][16];
    int         m_en [NSPR];
    int         m_x [NSPR];
    int         m_y [NSPR];
    int         m_sel [NSPR];

    always #5 clock = ~clock;

    mov_sprite_scheduler #(.NUM_SPR(NSPR), .COORD_W(CW), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_sel(cfg_sel), .cfg_en(cfg_en),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y),
        .mem_x(mem_x), .mem_y(mem_y), .mem_select(mem_select),
        .mem_data(mem_data),
        .out_valid(out_valid), .out_pixel(out_pixel),
        .out_hit(out_hit), .out_idx(out_idx)
    );

    // Sprite memory: combinational pattern lookup plus LAT-1 register stages.
    logic [1:0] rd;
    logic [1:0] dly [4];
    assign rd = pat[mem_select][mem_y][mem_x];
    always @(posedge clock) begin
        dly[0] <= rd;
        for (int k = 1; k < 4; k++) dly[k] <= dly[k-1];
    end
    generate
        if (LAT == 1) begin : g_l1
            assign mem_data = rd;
        end else begin : g_ln
            assign mem_data = dly[LAT-2];
        end
    endgenerate

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: visit entries in priority order; each visited entry costs
    // one clock, each overlapping entry additionally costs LAT clocks.
    task automatic model(input int px, input int py,
                         output int e_hit, output int e_pix, output int e_idx,
                         output int e_lat, output int e_any,
                         output int e_mx, output int e_my, output int e_ms);
        e_hit = 0; e_pix = 0; e_idx = 0; e_lat = 0; e_any = 0;
        e_mx = 0; e_my = 0; e_ms = 0;
        for (int i = 0; i < NSPR; i++) begin
            e_lat++;
            if (m_en[i] != 0 && px >= m_x[i] && px - m_x[i] < 16
                && py >= m_y[i] && py - m_y[i] < 16) begin
                e_lat += LAT;
                e_any = 1;
                e_mx = px - m_x[i];
                e_my = py - m_y[i];
                e_ms = m_sel[i];
                if (pat[e_ms][e_my][e_mx] != 2'd0) begin
                    e_hit = 1;
                    e_pix = int'(pat[e_ms][e_my][e_mx]);
                    e_idx = i;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NSPR; i++) m_en[i] = 0;
    endtask

    task automatic drive_cfg(input int i, input int x, input int y,
                             input int s, input int en);
        cfg_we  = 1'b1;
        cfg_idx = IW'(i);
        cfg_x   = CW'(x);
        cfg_y   = CW'(y);
        cfg_sel = 6'(s);
        cfg_en  = (en != 0);
        m_en[i] = en; m_x[i] = x; m_y[i] = y; m_sel[i] = s;
    endtask

    task automatic wr_ent(input int i, input int x, input int y,
                          input int s, input int en);
        drive_cfg(i, x, y, s, en);
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
    endtask

    // Issue one request; optionally a table write in the accept cycle.
    task automatic req(input int px, input int py, input bit wr,
                       input int wi, input int wx, input int wy,
                       input int ws, input int wen);
        int e_hit, e_pix, e_idx, e_lat, e_any, e_mx, e_my, e_ms;
        int cyc;
        check_eq("ready_idle", int'(pix_ready), 1);
        pix_valid = 1'b1;
        pix_x = CW'(px);
        pix_y = CW'(py);
        if (wr) drive_cfg(wi, wx, wy, ws, wen);
        model(px, py, e_hit, e_pix, e_idx, e_lat, e_any, e_mx, e_my, e_ms);
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
        cfg_we = 1'b0;
        pix_x = '0;
        pix_y = '0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check_eq("latency", cyc, e_lat);
        check_eq("out_hit", int'(out_hit), e_hit);
        check_eq("out_pixel", int'(out_pixel), e_pix);
        check_eq("out_idx", int'(out_idx), e_idx);
        if (e_any != 0) begin
            check_eq("mem_x", int'(mem_x), e_mx);
            check_eq("mem_y", int'(mem_y), e_my);
            check_eq("mem_select", int'(mem_select), e_ms);
        end
        @(posedge clock);
        #1;
        check_eq("pulse_end", int'(out_valid), 0);
        check_eq("hold_pixel", int'(out_pixel), e_pix);
        check_eq("hold_idx", int'(out_idx), e_idx);
    endtask

    task automatic req0(input int px, input int py);
        req(px, py, 1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
        cfg_sel = '0; cfg_en = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        for (int s = 0; s < 64; s++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    pat[s][r][c] = ($urandom_range(0, 9) < 4) ? 2'd0
                                   : 2'($urandom_range(1, 3));
        do_reset();

        check_eq("rst_ready", int'(pix_ready), 1);
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_hit", int'(out_hit), 0);
        check_eq("rst_pixel", int'(out_pixel), 0);
        check_eq("rst_idx", int'(out_idx), 0);
        check_eq("rst_mem_x", int'(mem_x), 0);
        check_eq("rst_mem_sel", int'(mem_select), 0);

        // Empty table.
        req0(5, 5);

        // Single instance, pixel 3.
        pat[1][3][7] = 2'd3;
        wr_ent(2, 100, 40, 1, 1);
        req0(107, 43);
        check_eq("t2_idx", int'(out_idx), 2);

        // Overlap: transparent entry 0 falls through to entry 3, then wins.
        do_reset();
        pat[4][5][10] = 2'd0;
        pat[5][10][5] = 2'd2;
        wr_ent(0, 40, 45, 4, 1);
        wr_ent(3, 45, 40, 5, 1);
        req0(50, 50);
        check_eq("t3_idx3", int'(out_idx), 3);
        pat[4][5][10] = 2'd1;
        req0(50, 50);
        check_eq("t3_idx0", int'(out_idx), 0);

        // Right screen edge: clipped, no wrap.
        do_reset();
        pat[7][5][5] = 2'd2;
        wr_ent(0, 1015, 0, 7, 1);
        req0(3, 5);
        req0(1020, 5);
        check_eq("t4_mem_x", int'(mem_x), 5);

        // Footprint boundaries.
        pat[9][0][15] = 2'd1;
        pat[9][15][0] = 2'd3;
        wr_ent(1, 200, 100, 9, 1);
        req0(215, 100);
        req0(216, 100);
        req0(200, 115);
        req0(200, 116);
        req0(199, 100);

        // Reset during WAIT aborts the request and clears the table.
        do_reset();
        pat[11][0][0] = 2'd2;
        wr_ent(0, 10, 10, 11, 1);
        pix_valid = 1'b1;
        pix_x = CW'(10);
        pix_y = CW'(10);
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NSPR; i++) m_en[i] = 0;
        check_eq("abort_ready", int'(pix_ready), 1);
        check_eq("abort_hit", int'(out_hit), 0);
        check_eq("abort_mem_x", int'(mem_x), 0);
        check_eq("abort_mem_sel", int'(mem_select), 0);
        for (int k = 0; k < 4; k++) begin
            check_eq("abort_no_valid", int'(out_valid), 0);
            @(posedge clock);
            #1;
        end
        req0(10, 10);

        // Write in the accept cycle is seen by the scan of that entry.
        pat[12][2][3] = 2'd1;
        req(33, 22, 1'b1, 5, 30, 20, 12, 1);
        check_eq("same_cycle_idx", int'(out_idx), 5);

        // Randomized table contents and requests.
        do_reset();
        for (int i = 0; i < NSPR; i++)
            wr_ent(i, $urandom_range(0, 70), $urandom_range(0, 70),
                   $urandom_range(0, 63), 1);
        for (int n = 0; n < 300; n++) begin
            int sx;
            if ($urandom_range(0, 3) == 0) begin
                sx = ($urandom_range(0, 9) == 0) ? $urandom_range(1008, 1023)
                                                 : $urandom_range(0, 70);
                wr_ent($urandom_range(0, NSPR - 1), sx, $urandom_range(0, 70),
                       $urandom_range(0, 63), ($urandom_range(0, 4) != 0));
            end
            if ($urandom_range(0, 7) == 0)
                req($urandom_range(0, 90), $urandom_range(0, 90), 1'b1,
                    $urandom_range(0, NSPR - 1), $urandom_range(0, 70),
                    $urandom_range(0, 70), $urandom_range(0, 63),
                    ($urandom_range(0, 3) != 0));
            else if ($urandom_range(0, 9) == 0)
                req0($urandom_range(1000, 1023), $urandom_range(0, 90));
            else
                req0($urandom_range(0, 90), $urandom_range(0, 90));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
